// File: rtl/seg_scan_decoder.sv
// Rebuilds six hex digits from a multiplexed 7-segment bus. Each completed scan frame yields one registered digit word.
// Latency: a digit is accepted STABLE_CYC edges after its inputs settle; frame_valid follows the 6th accept by one cycle.
// Backpressure: none. This is a passive monitor and never stalls the bus it observes.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-low reset
//   seg[7:0]      segments a..g on bits 0..6 (active-high); bit 7 is the decimal point and is ignored
//   seg_sel[5:0]  one-hot digit select, bit 0 = rightmost digit; polarity set by SEL_ACT_LOW
//   digits[23:0]  last complete frame, nibble k = digit shown while seg_sel bit k was active
//   frame_valid   1-cycle pulse when digits updates
//   frame_err     set when the last frame contained at least one undecodable pattern
//   code_err      1-cycle pulse when an accepted pattern is not a hex glyph
//   sel_err       1-cycle pulse when seg_sel is multi-hot
//   scan_lost     set after TIMEOUT_CYC cycles without an accept; cleared by the next accept
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter bit SEL_ACT_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [5:0]  seg_sel,
  output logic [23:0] digits,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        code_err,
  output logic        sel_err,
  output logic        scan_lost
);

  localparam int SW = $clog2(STABLE_CYC) + 1;
  localparam int IW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {IDLE, DWELL, HOLD} state_t;

  state_t        state_q;
  logic [7:0]    s_seg_q, p_seg_q;   // current and previous normalised samples
  logic [5:0]    s_sel_q, p_sel_q;
  logic [SW-1:0] stab_q;
  logic [IW-1:0] idle_q;
  logic [23:0]   shadow_q, shadow_d;
  logic [5:0]    seen_q;
  logic          bad_q;
  logic [23:0]   digits_q;
  logic          frame_valid_q, frame_err_q, code_err_q, sel_err_q, scan_lost_q;

  logic [5:0]    sel_n;
  logic          sel_zero, sel_onehot, sel_multi, same;
  logic [3:0]    code_val;
  logic          code_ok;
  logic [2:0]    idx;
  logic          accept;
  logic [5:0]    seen_acc;
  logic          frame_done;

  assign sel_n      = SEL_ACT_LOW ? ~seg_sel : seg_sel;
  assign sel_zero   = (s_sel_q == 6'd0);
  assign sel_onehot = !sel_zero && ((s_sel_q & (s_sel_q - 6'd1)) == 6'd0);
  assign sel_multi  = !sel_zero && !sel_onehot;
  assign same       = (s_seg_q == p_seg_q) && (s_sel_q == p_sel_q);

  // The sample that brought us into DWELL counts as the first stable one, so
  // the accept fires on the edge that would move stab_q to STABLE_CYC-1.
  assign accept     = (state_q == DWELL) && same && (stab_q == SW'(STABLE_CYC - 2));
  assign seen_acc   = seen_q | s_sel_q;
  assign frame_done = accept && (seen_acc == 6'h3F);

  always_comb begin
    code_ok  = 1'b1;
    code_val = 4'h0;
    case (s_seg_q[6:0])
      7'h3F: code_val = 4'h0;
      7'h06: code_val = 4'h1;
      7'h5B: code_val = 4'h2;
      7'h4F: code_val = 4'h3;
      7'h66: code_val = 4'h4;
      7'h6D: code_val = 4'h5;
      7'h7D: code_val = 4'h6;
      7'h07: code_val = 4'h7;
      7'h7F: code_val = 4'h8;
      7'h6F: code_val = 4'h9;
      7'h77: code_val = 4'hA;
      7'h7C: code_val = 4'hB;
      7'h39: code_val = 4'hC;
      7'h5E: code_val = 4'hD;
      7'h79: code_val = 4'hE;
      7'h71: code_val = 4'hF;
      default: code_ok = 1'b0;
    endcase
  end

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (s_sel_q[i]) idx = 3'(i);
    end
  end

  // An undecodable pattern leaves the previous nibble for that position in place.
  always_comb begin
    shadow_d = shadow_q;
    if (accept && code_ok) shadow_d[{idx, 2'b00} +: 4] = code_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      s_seg_q       <= 8'd0;
      s_sel_q       <= 6'd0;
      p_seg_q       <= 8'd0;
      p_sel_q       <= 6'd0;
      stab_q        <= '0;
      idle_q        <= '0;
      shadow_q      <= 24'd0;
      seen_q        <= 6'd0;
      bad_q         <= 1'b0;
      digits_q      <= 24'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      code_err_q    <= 1'b0;
      sel_err_q     <= 1'b0;
      scan_lost_q   <= 1'b0;
    end else begin
      s_seg_q       <= seg & 8'h7F;
      s_sel_q       <= sel_n;
      p_seg_q       <= s_seg_q;
      p_sel_q       <= s_sel_q;
      frame_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      sel_err_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (sel_onehot) begin
            state_q <= DWELL;
            stab_q  <= '0;
          end else if (sel_multi) begin
            sel_err_q <= 1'b1;
          end
        end
        DWELL: begin
          if (!same) begin
            if (sel_onehot) begin
              stab_q <= '0;
            end else begin
              state_q <= IDLE;
              if (sel_multi) sel_err_q <= 1'b1;
            end
          end else if (accept) begin
            state_q <= HOLD;
          end else begin
            stab_q <= stab_q + SW'(1);
          end
        end
        HOLD: begin
          // Only a change in either bus re-arms acceptance, so one dwell gives one accept.
          if (!same) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        shadow_q    <= shadow_d;
        code_err_q  <= !code_ok;
        idle_q      <= '0;
        scan_lost_q <= 1'b0;
        if (frame_done) begin
          digits_q      <= shadow_d;
          frame_valid_q <= 1'b1;
          frame_err_q   <= bad_q | !code_ok;
          seen_q        <= 6'd0;
          bad_q         <= 1'b0;
        end else begin
          seen_q <= seen_acc;
          bad_q  <= bad_q | !code_ok;
        end
      end else if (idle_q != IW'(TIMEOUT_CYC)) begin
        idle_q <= idle_q + IW'(1);
        // A stalled scan abandons the partial frame; digits keeps the last good one.
        if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
          scan_lost_q <= 1'b1;
          seen_q      <= 6'd0;
          bad_q       <= 1'b0;
        end
      end
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign code_err    = code_err_q;
  assign sel_err     = sel_err_q;
  assign scan_lost   = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  seg;
  logic [5:0]  seg_sel;
  logic [23:0] digits;
  logic        frame_valid, frame_err, code_err, sel_err, scan_lost;

  int errors = 0;
  int checks = 0;
  int n_frames = 0;
  int n_code = 0;
  int n_sel = 0;
  int exp_frames = 0;
  int snap_code, snap_sel;

  // Scoreboard entries: {frame_err, digits}
  logic [24:0] exp_q[$];

  seg_scan_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(4096), .SEL_ACT_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .seg(seg), .seg_sel(seg_sel),
    .digits(digits), .frame_valid(frame_valid), .frame_err(frame_err),
    .code_err(code_err), .sel_err(sel_err), .scan_lost(scan_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Output monitor: pops the scoreboard on every frame_valid pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_valid) begin
        n_frames++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          chk("frame_digits", {8'd0, digits}, {8'd0, e[23:0]});
          chk("frame_err", {31'd0, frame_err}, {31'd0, e[24]});
        end
      end
      if (code_err) n_code++;
      if (sel_err) n_sel++;
    end
  end

  task automatic drive(input logic [5:0] sel, input logic [7:0] sg, input int n);
    seg_sel = sel;
    seg     = sg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // segs[8k+7:8k] is shown on seg_sel bit k, each digit held for 8 cycles.
  task automatic scan(input logic [47:0] segs, input int first, input int last);
    for (int k = first; k <= last; k++) drive(6'(1 << k), segs[8*k +: 8], 8);
    drive(6'd0, 8'd0, 2);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    seg     = 8'd0;
    seg_sel = 6'd0;
    #12;
    chk("rst_digits", {8'd0, digits}, 32'd0);
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_code_err", {31'd0, code_err}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_scan_lost", {31'd0, scan_lost}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(6'd0, 8'd0, 3);

    // Digits 1..6 on positions 0..5
    snap_code = n_code; snap_sel = n_sel;
    exp_q.push_back({1'b0, 24'h654321}); exp_frames++;
    scan({8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06}, 0, 5);
    wait_drain("t1_drain");
    chk("t1_frames", n_frames, exp_frames);
    chk("t1_no_code_err", n_code - snap_code, 32'd0);
    chk("t1_no_sel_err", n_sel - snap_sel, 32'd0);

    // Decimal point set on position 2 must not disturb decoding
    snap_code = n_code;
    exp_q.push_back({1'b0, 24'h654021}); exp_frames++;
    scan({8'h7D, 8'h6D, 8'h66, 8'hBF, 8'h5B, 8'h06}, 0, 5);
    wait_drain("t2_drain");
    chk("t2_frames", n_frames, exp_frames);
    chk("t2_no_code_err", n_code - snap_code, 32'd0);

    // Blank pattern on position 3: nibble keeps the previous value (4)
    snap_code = n_code;
    exp_q.push_back({1'b1, 24'hBA4987}); exp_frames++;
    scan({8'h7C, 8'h77, 8'h00, 8'h6F, 8'h7F, 8'h07}, 0, 5);
    wait_drain("t4_drain");
    chk("t4_frames", n_frames, exp_frames);
    chk("t4_code_err_once", n_code - snap_code, 32'd1);
    chk("t4_frame_err_level", {31'd0, frame_err}, 32'd1);

    // Multi-hot select: sel_err, no accept, then a clean frame
    snap_sel = n_sel;
    drive(6'b000011, 8'h06, 10);
    drive(6'd0, 8'd0, 8);
    chk("t5_sel_err_seen", (n_sel - snap_sel) > 0, 32'd1);
    chk("t5_no_frame", n_frames, exp_frames);
    exp_q.push_back({1'b0, 24'h10FEDC}); exp_frames++;
    scan({8'h06, 8'h3F, 8'h71, 8'h79, 8'h5E, 8'h39}, 0, 5);
    wait_drain("t5_drain");
    chk("t5_frames", n_frames, exp_frames);
    chk("t5_frame_err_cleared", {31'd0, frame_err}, 32'd0);

    // Glitchy scan: every digit held one cycle too short
    chk("t3_not_lost_yet", {31'd0, scan_lost}, 32'd0);
    for (int i = 0; i < 1400; i++) drive(6'(1 << (i % 6)), 8'h5B, 3);
    drive(6'd0, 8'd0, 2);
    chk("t3_scan_lost", {31'd0, scan_lost}, 32'd1);
    chk("t3_no_frame", n_frames, exp_frames);
    chk("t3_digits_kept", {8'd0, digits}, 32'h0010FEDC);

    // First accept clears scan_lost
    drive(6'b000001, 8'h06, 8);
    chk("t6_scan_lost_cleared", {31'd0, scan_lost}, 32'd0);
    scan({8'h00, 8'h00, 8'h00, 8'h4F, 8'h5B, 8'h06}, 1, 2);
    chk("t6_partial_no_frame", n_frames, exp_frames);

    // Reset mid-frame: digits clears asynchronously
    reset = 1'b0;
    #1;
    chk("t6_rst_digits", {8'd0, digits}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(6'd0, 8'd0, 2);
    scan({8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F}, 0, 4);
    chk("t6_five_no_frame", n_frames, exp_frames);
    exp_q.push_back({1'b0, 24'h456789}); exp_frames++;
    scan({8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F}, 5, 5);
    wait_drain("t6_drain");
    chk("t6_frames", n_frames, exp_frames);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
